akkanat_dmem: RTL and testbench

AKKANAT_DMEM -- requirements
Module: akkanat_dmem

---
 rtl/akkanat_dmem.sv | 204 ++++++++++++++++++++
 tb/tb_akkanat_dmem.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/akkanat_dmem.sv
// Word-addressed data memory for the akkanat core, with an optional MMIO block (DMEM_MMIO_EN):
// CYCLE and WCNT counters, a console FIFO and a STATUS register at 0xFFFF_0000..0xFFFF_000C.
module akkanat_dmem #(
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        we_i,
   output logic [31:0] rdata_o,
   output logic        err_o,
   input  logic        err_clr_i,
   output logic        out_valid_o,
   output logic [31:0] out_data_o,
   input  logic        out_ready_i
);

   localparam int unsigned Aw       = $clog2(DEPTH);
   localparam logic [31:0] RamBytes = 32'(4 * DEPTH);

   logic [31:0]   mem_q [DEPTH];
   logic [Aw-1:0] word_idx;
   logic          aligned;
   logic          in_ram;
   logic          ram_hit;
   logic          ram_we;
   logic          mmio_hit;
   logic [31:0]   mmio_rdata;
   logic          err_d, err_q;

   assign aligned  = (addr_i[1:0] == 2'b00);
   assign in_ram   = (addr_i < RamBytes);
   assign ram_hit  = aligned & in_ram;
   assign word_idx = addr_i[Aw+1:2];
   assign ram_we   = we_i & ram_hit;

   // Combinational read: the core samples rdata in the same cycle it drives the address.
   always_comb begin
      rdata_o = mmio_rdata;
      if (ram_hit) begin
         rdata_o = mem_q[word_idx];
      end
   end

   // Re-writing the same word on the core's second strobe cycle is harmless.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (ram_we) begin
         mem_q[word_idx] <= wdata_i;
      end
   end

   // Any cycle whose address decodes to nothing raises the sticky error; a set beats a clear.
   always_comb begin
      err_d = err_q;
      if (err_clr_i) begin
         err_d = 1'b0;
      end
      if (!(ram_hit || mmio_hit)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;

`ifdef DMEM_MMIO_EN
   localparam int unsigned FAw      = $clog2(FIFO_DEPTH);
   localparam logic [FAw:0] CntOne  = (FAw+1)'(1);
   localparam logic [FAw:0] CntFull = (FAw+1)'(FIFO_DEPTH);
   localparam logic [FAw-1:0] PtrOne = FAw'(1);

   logic          cycle_hit, wcnt_hit, con_hit, stat_hit;
   logic [31:0]   cycle_d, cycle_q;
   logic [31:0]   wcnt_d, wcnt_q;
   logic          hist_we_d, hist_we_q;
   logic [31:0]   hist_addr_d, hist_addr_q;
   logic [31:0]   hist_wdata_d, hist_wdata_q;
   logic          new_write;
   logic          push, pop, do_push;
   logic          full, empty;
   logic          ovf_d, ovf_q;
   logic [FAw-1:0] wr_ptr_d, wr_ptr_q;
   logic [FAw-1:0] rd_ptr_d, rd_ptr_q;
   logic [FAw:0]   cnt_d, cnt_q;
   logic [31:0]    fifo_q [FIFO_DEPTH];

   assign cycle_hit = (addr_i == 32'hFFFF_0000);
   assign wcnt_hit  = (addr_i == 32'hFFFF_0004);
   assign con_hit   = (addr_i == 32'hFFFF_0008);
   assign stat_hit  = (addr_i == 32'hFFFF_000C);
   assign mmio_hit  = cycle_hit | wcnt_hit | con_hit | stat_hit;

   // A held strobe with unchanged address and data is the same store, not a new one.
   assign new_write = we_i & ~(hist_we_q & (hist_addr_q == addr_i) & (hist_wdata_q == wdata_i));

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CntFull);
   assign push    = new_write & con_hit;
   assign pop     = ~empty & out_ready_i;
   assign do_push = push & (~full | pop);

   always_comb begin
      mmio_rdata = '0;
      if (cycle_hit) begin
         mmio_rdata = cycle_q;
      end else if (wcnt_hit) begin
         mmio_rdata = wcnt_q;
      end else if (stat_hit) begin
         mmio_rdata = {28'b0, ovf_q, err_q, full, empty};
      end
   end

   always_comb begin
      cycle_d      = cycle_q + 32'd1;
      wcnt_d       = wcnt_q;
      hist_we_d    = we_i;
      hist_addr_d  = addr_i;
      hist_wdata_d = wdata_i;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      cnt_d        = cnt_q;
      ovf_d        = ovf_q;
      if (new_write && ram_hit) begin
         wcnt_d = wcnt_q + 32'd1;
      end
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrOne;
      end
      unique case ({do_push, pop})
         2'b10:   cnt_d = cnt_q + CntOne;
         2'b01:   cnt_d = cnt_q - CntOne;
         default: cnt_d = cnt_q;
      endcase
      if (err_clr_i) begin
         ovf_d = 1'b0;
      end
      if (push && full && !pop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cycle_q      <= '0;
         wcnt_q       <= '0;
         hist_we_q    <= 1'b0;
         hist_addr_q  <= '0;
         hist_wdata_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
      end else begin
         cycle_q      <= cycle_d;
         wcnt_q       <= wcnt_d;
         hist_we_q    <= hist_we_d;
         hist_addr_q  <= hist_addr_d;
         hist_wdata_q <= hist_wdata_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else if (do_push) begin
         fifo_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign out_valid_o = ~empty;
   assign out_data_o  = empty ? 32'd0 : fifo_q[rd_ptr_q];
`else
   logic unused_ok;

   assign mmio_hit    = 1'b0;
   assign mmio_rdata  = '0;
   assign out_valid_o = 1'b0;
   assign out_data_o  = '0;
   assign unused_ok   = out_ready_i ^ (FIFO_DEPTH == 0);
`endif

endmodule

// File: tb/tb_akkanat_dmem.sv
// Directed bench for akkanat_dmem; covers the MMIO block only when DMEM_MMIO_EN is defined.
module tb_akkanat_dmem;

   localparam int unsigned DEPTH      = 256;
   localparam int unsigned FIFO_DEPTH = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] addr_i = 32'h0;
   logic [31:0] wdata_i = 32'h0;
   logic        we_i = 1'b0;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        err_clr_i = 1'b0;
   logic        out_valid_o;
   logic [31:0] out_data_o;
   logic        out_ready_i = 1'b0;

   int n_vec  = 0;
   int n_miss = 0;

   akkanat_dmem #(
      .DEPTH      (DEPTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .we_i        (we_i),
      .rdata_o     (rdata_o),
      .err_o       (err_o),
      .err_clr_i   (err_clr_i),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_ready_i (out_ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance to just past the next rising edge.
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_err();
      err_clr_i = 1'b1;
      cyc();
      err_clr_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      #2;
      addr_i = 32'h10;
      #1;
      check_eq("rst_rdata", rdata_o, 32'h0);
      check_eq("rst_err", {31'b0, err_o}, 32'h0);
      check_eq("rst_valid", {31'b0, out_valid_o}, 32'h0);
      check_eq("rst_odata", out_data_o, 32'h0);
`ifdef DMEM_MMIO_EN
      addr_i = 32'hFFFF_0000;
`endif
      #8 rst_i = 1'b0;
      cyc();
`ifdef DMEM_MMIO_EN
      check_eq("cycle_first", rdata_o, 32'h1);
`endif

      // Store: two-cycle strobe writes once
      addr_i = 32'h10; wdata_i = 32'hDEAD_BEEF; we_i = 1'b1;
      cyc(); cyc();
      we_i = 1'b0;
      #1;
      check_eq("store_rd", rdata_o, 32'hDEAD_BEEF);
`ifdef DMEM_MMIO_EN
      addr_i = 32'hFFFF_0004; #1;
      check_eq("wcnt_1", rdata_o, 32'h1);
`endif
      addr_i = 32'h14; wdata_i = 32'h0123_4567; we_i = 1'b1;
      cyc(); cyc();
      we_i = 1'b0; cyc();
      check_eq("store2_rd", rdata_o, 32'h0123_4567);
      addr_i = 32'h10; wdata_i = 32'hDEAD_BEEF; we_i = 1'b1;
      cyc();
      we_i = 1'b0; #1;
      check_eq("store1_keep", rdata_o, 32'hDEAD_BEEF);
`ifdef DMEM_MMIO_EN
      addr_i = 32'hFFFF_0004; #1;
      check_eq("wcnt_3", rdata_o, 32'h3);
      addr_i = 32'h10;
`endif
      check_eq("err_clean", {31'b0, err_o}, 32'h0);

      // Misaligned write dropped, sticky error then cleared
      addr_i = 32'h13; wdata_i = 32'h1234_5678; we_i = 1'b1; #1;
      check_eq("mis_rdata", rdata_o, 32'h0);
      cyc();
      we_i = 1'b0; addr_i = 32'h10; #1;
      check_eq("mis_err", {31'b0, err_o}, 32'h1);
      check_eq("mis_keep", rdata_o, 32'hDEAD_BEEF);
      cyc();
      check_eq("err_sticky", {31'b0, err_o}, 32'h1);
      clear_err();
      check_eq("err_clr", {31'b0, err_o}, 32'h0);

      // Out of range and last word
      addr_i = 4 * DEPTH; #1;
      check_eq("oor_rdata", rdata_o, 32'h0);
      cyc();
      addr_i = 32'h10; #1;
      check_eq("oor_err", {31'b0, err_o}, 32'h1);
      clear_err();
      addr_i = 4 * DEPTH - 4; wdata_i = 32'hCAFE_F00D; we_i = 1'b1;
      cyc(); cyc();
      we_i = 1'b0; #1;
      check_eq("last_word", rdata_o, 32'hCAFE_F00D);
      check_eq("last_noerr", {31'b0, err_o}, 32'h0);
      addr_i = 4 * DEPTH; wdata_i = 32'h5555_5555; we_i = 1'b1;
      cyc();
      we_i = 1'b0; addr_i = 32'h0; #1;
      check_eq("oor_nowrap", rdata_o, 32'h0);
      clear_err();

      // Set wins over clear
      addr_i = 32'h2; err_clr_i = 1'b1;
      cyc();
      err_clr_i = 1'b0; addr_i = 32'h10; #1;
      check_eq("set_wins", {31'b0, err_o}, 32'h1);
      clear_err();
      check_eq("err_clr2", {31'b0, err_o}, 32'h0);

`ifdef DMEM_MMIO_EN
      // Console: one entry per two-cycle strobe
      addr_i = 32'hFFFF_0008; wdata_i = 32'h41; we_i = 1'b1; #1;
      check_eq("con_read0", rdata_o, 32'h0);
      cyc(); cyc();
      we_i = 1'b0; addr_i = 32'hFFFF_000C; #1;
      check_eq("con_valid", {31'b0, out_valid_o}, 32'h1);
      check_eq("con_head", out_data_o, 32'h41);
      check_eq("con_status", rdata_o, 32'h0);
      out_ready_i = 1'b1;
      cyc();
      out_ready_i = 1'b0; #1;
      check_eq("con_one", {31'b0, out_valid_o}, 32'h0);
      check_eq("con_empty", rdata_o, 32'h1);

      // Overflow on the fifth push, then drain in order
      addr_i = 32'hFFFF_0008; we_i = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         wdata_i = i;
         cyc();
      end
      we_i = 1'b0; addr_i = 32'hFFFF_000C; #1;
      check_eq("ovf_status", rdata_o, 32'hA);
      out_ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         check_eq("drain", out_data_o, i);
         cyc();
      end
      out_ready_i = 1'b0; #1;
      check_eq("drain_done", {31'b0, out_valid_o}, 32'h0);
      clear_err();
      #1;
      check_eq("ovf_clr", rdata_o, 32'h1);

      // Push and pop together while full
      addr_i = 32'hFFFF_0008; we_i = 1'b1;
      for (int i = 10; i <= 13; i++) begin
         wdata_i = i;
         cyc();
      end
      wdata_i = 14; out_ready_i = 1'b1;
      cyc();
      we_i = 1'b0; out_ready_i = 1'b0; addr_i = 32'hFFFF_000C; #1;
      check_eq("full_pp_stat", rdata_o, 32'h2);
      out_ready_i = 1'b1;
      for (int i = 11; i <= 14; i++) begin
         #1;
         check_eq("full_pp_drain", out_data_o, i);
         cyc();
      end

      // No bypass on push while empty
      addr_i = 32'hFFFF_0008; wdata_i = 32'h77; we_i = 1'b1; #1;
      check_eq("nobypass", {31'b0, out_valid_o}, 32'h0);
      cyc();
      we_i = 1'b0; #1;
      check_eq("nob_valid", {31'b0, out_valid_o}, 32'h1);
      check_eq("nob_data", out_data_o, 32'h77);
      cyc();
      out_ready_i = 1'b0; #1;
      check_eq("nob_popped", {31'b0, out_valid_o}, 32'h0);

      // Reset mid-operation with two entries queued
      addr_i = 32'hFFFF_0008; we_i = 1'b1; wdata_i = 32'hA1;
      cyc();
      wdata_i = 32'hA2;
      cyc();
      we_i = 1'b0; addr_i = 32'hFFFF_000C; #1;
      check_eq("pre_rst_stat", rdata_o, 32'h0);
      rst_i = 1'b1; #1;
      check_eq("rst_valid2", {31'b0, out_valid_o}, 32'h0);
      check_eq("rst_stat2", rdata_o, 32'h1);
      addr_i = 32'h10; #1;
      check_eq("rst_ram", rdata_o, 32'h0);
      addr_i = 32'hFFFF_0000;
      rst_i = 1'b0;
      cyc();
      check_eq("cycle_after", rdata_o, 32'h1);
      addr_i = 32'hFFFF_0004; #1;
      check_eq("wcnt_rst", rdata_o, 32'h0);
`else
      // MMIO window decodes as invalid
      addr_i = 32'hFFFF_0000; #1;
      check_eq("nommio_rd", rdata_o, 32'h0);
      cyc();
      addr_i = 32'h8; #1;
      check_eq("nommio_err", {31'b0, err_o}, 32'h1);
      clear_err();
      addr_i = 32'hFFFF_0008; wdata_i = 32'h41; we_i = 1'b1;
      cyc(); cyc();
      we_i = 1'b0; addr_i = 32'h8; #1;
      check_eq("nommio_nowr", rdata_o, 32'h0);
      check_eq("nommio_valid", {31'b0, out_valid_o}, 32'h0);
      check_eq("nommio_odata", out_data_o, 32'h0);
      rst_i = 1'b1; #1;
      check_eq("rst_err2", {31'b0, err_o}, 32'h0);
      addr_i = 32'h10; #1;
      check_eq("rst_ram", rdata_o, 32'h0);
      rst_i = 1'b0;
      cyc();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
